vel_ramp_ctrl: RTL and testbench
================================

VEL_RAMP_CTRL -- requirements
Module: vel_ramp_ctrl

Interface
REQ-001 Parameter STEP_CYCLES, default 50000; clock cycles between successive speed-level steps; legal range 1..65535.
REQ-002 Parameter DEAD_CYCLES, default 25000; clock cycles of dwell at level 0 before a direction change; legal range 1..65535.
REQ-003 clk_i  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid_i  input  1  speed command present.
REQ-006 cmd_vel_i  input  3  requested speed level; 0 = stop, 1..5 = speed levels.
REQ-007 cmd_dir_i  input  1  requested direction; 0 = forward, 1 = reverse.
REQ-008 cmd_ready_o  output  1  controller can accept a command this cycle.
REQ-009 estop_i  input  1  emergency stop, level-sensitive, synchronous.
REQ-010 velCase_o  output  3  speed level driven into the PWM speed generator.
REQ-011 dir_o  output  1  direction driven to the motor bridge.
REQ-012 done_o  output  1  single-cycle pulse when a command completes.

Function
REQ-013 The block SHALL use the states IDLE, RAMP, BRAKE, DEAD and ESTOP.
REQ-014 cmd_ready_o SHALL be 1 only when the state is IDLE and estop_i is 0.
REQ-015 A command SHALL be accepted at the rising edge where cmd_valid_i and cmd_ready_o are both 1; cmd_vel_i and cmd_dir_i SHALL be latched at that edge.
REQ-016 A latched target of 6 or 7 SHALL be clamped to 5.
REQ-017 On acceptance with dir equal to dir_o and target equal to velCase_o, the state SHALL stay IDLE and done_o SHALL pulse in the following cycle.
REQ-018 On acceptance with dir equal to dir_o and a different target, the state SHALL go to RAMP.
REQ-019 On acceptance with dir different from dir_o, the state SHALL go to BRAKE if velCase_o is nonzero, and to DEAD if velCase_o is 0.
REQ-020 Step timer: 16-bit.
  - Cleared on acceptance and on every entry to RAMP or BRAKE.
  - Increments each cycle in RAMP and BRAKE.
  - When it equals STEP_CYCLES-1: velCase_o moves one level (toward the target in RAMP, toward 0 in BRAKE) and the timer clears.
  - The first step is therefore registered STEP_CYCLES edges after the entry edge.
REQ-021 RAMP SHALL complete at the edge that registers velCase_o equal to the target; at that edge the state SHALL become IDLE and done_o SHALL be 1 for that cycle only.
REQ-022 BRAKE SHALL go to DEAD at the edge that registers velCase_o equal to 0.
REQ-023 In DEAD, a counter SHALL count DEAD_CYCLES cycles; at the final edge dir_o SHALL take the latched direction.
  - If the target is 0: the state becomes IDLE with a done_o pulse.
  - Otherwise: the state becomes RAMP with the timer cleared.
REQ-024 dir_o SHALL never change while velCase_o is nonzero.
REQ-025 estop_i = 1 in any state SHALL, at the next edge, force velCase_o to 0, clear the timers and enter ESTOP.
  - dir_o is held.
  - No done_o pulse is generated.
  - The in-flight command is discarded.
REQ-026 ESTOP SHALL go to IDLE at the first edge with estop_i = 0.
REQ-027 estop_i SHALL take priority over a simultaneous command acceptance and over a simultaneous step.
REQ-028 cmd_valid_i outside IDLE SHALL be ignored; no buffering.

Reset
REQ-029 While rst_ni is 0, regardless of clock, the block SHALL hold:
  - state IDLE, velCase_o 0, dir_o 0, done_o 0;
  - timers 0, latched target 0, latched direction 0.
REQ-030 cmd_ready_o SHALL be 1 at the first edge after rst_ni rises, provided estop_i is 0.
REQ-031 Reset asserted mid-ramp SHALL return the block to the REQ-029 values with no done_o pulse.

Verification (STEP_CYCLES=4, DEAD_CYCLES=3)
REQ-032 Release reset with estop 0 -> velCase_o 0, dir_o 0, done_o 0, cmd_ready_o 1.
REQ-033 From 0/fwd, accept vel 3 dir 0 at edge T -> expected response:
  - velCase_o = 1 at T+4, 2 at T+8, 3 at T+12;
  - done_o pulses in the cycle after T+12;
  - cmd_ready_o is 0 from T+1 until T+12.
REQ-034 From 3/fwd, accept vel 2 dir 1 at T -> expected response:
  - velCase_o = 2, 1, 0 at T+4, T+8, T+12;
  - dir_o = 1 at T+15;
  - velCase_o = 1 at T+19 and 2 at T+23;
  - done_o pulses once, after T+23.
REQ-035 From 0, accept vel 7 -> ramps to 5 in 5 steps (velCase_o 5 at T+20), done_o pulses, and velCase_o never exceeds 5.
REQ-036 Assert estop_i at velCase_o 2 mid-ramp -> velCase_o 0 next edge, cmd_ready_o 0, no done_o; on release -> IDLE, ready 1, dir_o unchanged.
REQ-037 Pulse rst_ni low asynchronously mid-BRAKE -> outputs immediately match REQ-029; a new command after release behaves as in REQ-033.

Source files
------------

// File: rtl/vel_ramp_ctrl.sv
// vel_ramp_ctrl: stepped speed ramp with brake and dead-time
// on direction reversal, plus emergency stop.
module vel_ramp_ctrl #(
  parameter int unsigned STEP_CYCLES = 50000,
  parameter int unsigned DEAD_CYCLES = 25000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cmd_valid_i,
  input  logic [2:0] cmd_vel_i,
  input  logic       cmd_dir_i,
  output logic       cmd_ready_o,
  input  logic       estop_i,
  output logic [2:0] velCase_o,
  output logic       dir_o,
  output logic       done_o
);

  localparam logic [15:0] STEP_LAST = 16'(STEP_CYCLES - 1);
  localparam logic [15:0] DEAD_LAST = 16'(DEAD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    RAMP,
    BRAKE,
    DEAD,
    ESTOP
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  vel_q, vel_d;
  logic        dir_q, dir_d;
  logic        done_q, done_d;
  logic [15:0] tmr_q, tmr_d;
  logic [15:0] dcnt_q, dcnt_d;
  logic [2:0]  tgt_q, tgt_d;
  logic        ldir_q, ldir_d;
  logic [2:0]  tgt_in;
  logic [2:0]  vel_step;

  assign tgt_in   = (cmd_vel_i > 3'd5) ? 3'd5 : cmd_vel_i;
  assign vel_step = (vel_q < tgt_q) ? vel_q + 3'd1
                                    : vel_q - 3'd1;

  assign cmd_ready_o = (state_q == IDLE) && !estop_i;
  assign velCase_o   = vel_q;
  assign dir_o       = dir_q;
  assign done_o      = done_q;

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      vel_q   <= 3'd0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      tmr_q   <= 16'd0;
      dcnt_q  <= 16'd0;
      tgt_q   <= 3'd0;
      ldir_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vel_q   <= vel_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      tmr_q   <= tmr_d;
      dcnt_q  <= dcnt_d;
      tgt_q   <= tgt_d;
      ldir_q  <= ldir_d;
    end
  end

  // Next-state logic; estop overrides everything
  always_comb begin
    state_d = state_q;
    vel_d   = vel_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    tmr_d   = tmr_q;
    dcnt_d  = dcnt_q;
    tgt_d   = tgt_q;
    ldir_d  = ldir_q;
    if (estop_i) begin
      state_d = ESTOP;
      vel_d   = 3'd0;
      tmr_d   = 16'd0;
      dcnt_d  = 16'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            tgt_d  = tgt_in;
            ldir_d = cmd_dir_i;
            tmr_d  = 16'd0;
            dcnt_d = 16'd0;
            if (cmd_dir_i == dir_q) begin
              if (tgt_in == vel_q) done_d = 1'b1;
              else state_d = RAMP;
            end else if (vel_q != 3'd0) begin
              state_d = BRAKE;
            end else begin
              state_d = DEAD;
            end
          end
        end
        RAMP: begin
          if (tmr_q == STEP_LAST) begin
            tmr_d = 16'd0;
            vel_d = vel_step;
            if (vel_step == tgt_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            tmr_d = tmr_q + 16'd1;
          end
        end
        BRAKE: begin
          if (tmr_q == STEP_LAST) begin
            tmr_d = 16'd0;
            vel_d = vel_q - 3'd1;
            if (vel_q == 3'd1) begin
              state_d = DEAD;
              dcnt_d  = 16'd0;
            end
          end else begin
            tmr_d = tmr_q + 16'd1;
          end
        end
        DEAD: begin
          if (dcnt_q == DEAD_LAST) begin
            dcnt_d = 16'd0;
            dir_d  = ldir_q;
            if (tgt_q == 3'd0) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = RAMP;
              tmr_d   = 16'd0;
            end
          end else begin
            dcnt_d = dcnt_q + 16'd1;
          end
        end
        ESTOP: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vel_ramp_ctrl.sv
// tb_vel_ramp_ctrl: table vectors plus timed sequences,
// with a done_o scoreboard (STEP_CYCLES=4, DEAD_CYCLES=3).
module tb_vel_ramp_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       cmd_valid_i = 1'b0;
  logic [2:0] cmd_vel_i = 3'd0;
  logic       cmd_dir_i = 1'b0;
  logic       cmd_ready_o;
  logic       estop_i = 1'b0;
  logic [2:0] velCase_o;
  logic       dir_o;
  logic       done_o;

  vel_ramp_ctrl #(
    .STEP_CYCLES(4),
    .DEAD_CYCLES(3)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .cmd_valid_i(cmd_valid_i),
    .cmd_vel_i  (cmd_vel_i),
    .cmd_dir_i  (cmd_dir_i),
    .cmd_ready_o(cmd_ready_o),
    .estop_i    (estop_i),
    .velCase_o  (velCase_o),
    .dir_o      (dir_o),
    .done_o     (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0] vel;
    logic       dir;
    int         lat;
    int         fvel;
    int         fdir;
  } vec_t;

  typedef struct {
    int fvel;
    int fdir;
    int lat;
    int t;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  int   pvel = 0;
  int   pdir = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // done_o scoreboard and per-cycle invariants
  always @(negedge clk_i) begin
    exp_t e;
    if (mon_en) begin
      if (done_o) begin
        if (q.size() == 0) begin
          chk("spurious_done", int'(done_o), 0);
        end else begin
          e = q.pop_front();
          chk("done_vel", int'(velCase_o), e.fvel);
          chk("done_dir", int'(dir_o), e.fdir);
          chk("done_lat", cyc - e.t, e.lat);
        end
      end
      chk("vel_max", int'(velCase_o > 3'd5), 0);
      if (velCase_o != 3'd0 || pvel != 0)
        chk("dir_hold", int'(dir_o), pdir);
    end
    pvel <= int'(velCase_o);
    pdir <= int'(dir_o);
  end

  task automatic wait_edge(input int n);
    while (cyc < n) @(negedge clk_i);
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!cmd_ready_o && k < 100) begin
      @(negedge clk_i);
      k++;
    end
    chk("ready_wait", int'(cmd_ready_o), 1);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 200) begin
      @(negedge clk_i);
      k++;
    end
    chk("drain", q.size(), 0);
  endtask

  task automatic send(input logic [2:0] v, input logic d,
                      input bit push, input int lat,
                      input int fv, input int fd,
                      output int t);
    wait_ready();
    cmd_valid_i = 1'b1;
    cmd_vel_i   = v;
    cmd_dir_i   = d;
    t = cyc + 1;
    if (push) q.push_back('{fv, fd, lat, t});
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[7];
    int t;
    tbl[0] = '{3'd7, 1'b1, 12, 5, 1};
    tbl[1] = '{3'd5, 1'b1, 0,  5, 1};
    tbl[2] = '{3'd1, 1'b1, 16, 1, 1};
    tbl[3] = '{3'd0, 1'b0, 7,  0, 0};
    tbl[4] = '{3'd0, 1'b1, 3,  0, 1};
    tbl[5] = '{3'd6, 1'b0, 23, 5, 0};
    tbl[6] = '{3'd0, 1'b0, 20, 0, 0};

    // reset held, then released
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_vel", int'(velCase_o), 0);
    chk("rst_done", int'(done_o), 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("por_vel", int'(velCase_o), 0);
    chk("por_dir", int'(dir_o), 0);
    chk("por_done", int'(done_o), 0);
    chk("por_ready", int'(cmd_ready_o), 1);
    mon_en = 1'b1;

    // ramp 0 -> 3 forward
    send(3'd3, 1'b0, 1'b1, 12, 3, 0, t);
    for (int k = 1; k <= 12; k++) begin
      wait_edge(t + k);
      chk("ramp_ready", int'(cmd_ready_o), (k == 12) ? 1 : 0);
      if (k % 4 == 0) chk("ramp_vel", int'(velCase_o), k / 4);
    end
    wait_drain();

    // reversal 3/fwd -> 2/rev
    send(3'd2, 1'b1, 1'b1, 23, 2, 1, t);
    wait_edge(t + 4);  chk("rev_v4", int'(velCase_o), 2);
    wait_edge(t + 8);  chk("rev_v8", int'(velCase_o), 1);
    wait_edge(t + 12); chk("rev_v12", int'(velCase_o), 0);
    wait_edge(t + 14); chk("rev_d14", int'(dir_o), 0);
    wait_edge(t + 15); chk("rev_d15", int'(dir_o), 1);
    wait_edge(t + 19); chk("rev_v19", int'(velCase_o), 1);
    wait_edge(t + 23); chk("rev_v23", int'(velCase_o), 2);
    wait_drain();

    // table vectors
    for (int i = 0; i < 7; i++) begin
      send(tbl[i].vel, tbl[i].dir, 1'b1, tbl[i].lat,
           tbl[i].fvel, tbl[i].fdir, t);
      wait_drain();
      chk($sformatf("vec%0d_vel", i), int'(velCase_o), tbl[i].fvel);
      chk($sformatf("vec%0d_dir", i), int'(dir_o), tbl[i].fdir);
    end

    // estop mid-ramp, direction reverse
    send(3'd0, 1'b1, 1'b1, 3, 0, 1, t);
    wait_drain();
    send(3'd3, 1'b1, 1'b0, 0, 0, 0, t);
    wait_edge(t + 8);
    chk("es_pre_vel", int'(velCase_o), 2);
    estop_i = 1'b1;
    wait_edge(t + 9);
    chk("es_vel", int'(velCase_o), 0);
    chk("es_ready", int'(cmd_ready_o), 0);
    wait_edge(t + 11);
    chk("es_hold_ready", int'(cmd_ready_o), 0);
    chk("es_hold_vel", int'(velCase_o), 0);
    estop_i = 1'b0;
    wait_edge(t + 12);
    chk("es_rel_ready", int'(cmd_ready_o), 1);
    chk("es_rel_dir", int'(dir_o), 1);
    chk("es_rel_vel", int'(velCase_o), 0);

    // estop beats a simultaneous command
    estop_i = 1'b1;
    cmd_valid_i = 1'b1;
    cmd_vel_i = 3'd4;
    cmd_dir_i = 1'b1;
    #1 chk("es_cmd_ready", int'(cmd_ready_o), 0);
    @(negedge clk_i);
    estop_i = 1'b0;
    cmd_valid_i = 1'b0;
    @(negedge clk_i);
    chk("es_cmd_vel", int'(velCase_o), 0);
    chk("es_cmd_ready2", int'(cmd_ready_o), 1);

    // async reset mid-brake
    send(3'd2, 1'b1, 1'b1, 8, 2, 1, t);
    wait_drain();
    send(3'd1, 1'b0, 1'b0, 0, 0, 0, t);
    wait_edge(t + 5);
    chk("brk_vel", int'(velCase_o), 1);
    mon_en = 1'b0;
    #1 rst_ni = 1'b0;
    #1;
    chk("arst_vel", int'(velCase_o), 0);
    chk("arst_dir", int'(dir_o), 0);
    chk("arst_done", int'(done_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    mon_en = 1'b1;
    send(3'd3, 1'b0, 1'b1, 12, 3, 0, t);
    wait_edge(t + 4); chk("post_v4", int'(velCase_o), 1);
    wait_edge(t + 8); chk("post_v8", int'(velCase_o), 2);
    wait_drain();
    chk("post_dir", int'(dir_o), 0);

    repeat (3) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
